// File: rtl/commit_controller_if.sv
`timescale 1ns/1ps
// commit_controller_if
//   Bundles everything the commit controller exchanges with the ROB head,
//   the register file commit port, the LSB, and the fetch/flush fabric.
//   master : the commit controller (drives pop, RF write-back, flush, halt)
//   slave  : the surrounding pipeline (drives head fields, rdy, st_ack)
interface commit_controller_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 rdy_in;
  logic                 rob_head_valid;
  logic                 rob_head_done;
  logic [1:0]           rob_head_type;
  logic [4:0]           rob_head_rd;
  logic [31:0]          rob_head_val;
  logic [ROB_WIDTH-1:0] rob_head_index;
  logic                 rob_head_mispred;
  logic [31:0]          rob_head_target;
  logic                 rob_pop;
  logic                 rf_ready;
  logic [4:0]           rf_reg_id;
  logic [31:0]          rf_reg_val;
  logic [ROB_WIDTH-1:0] rf_rob_index;
  logic                 st_req;
  logic                 st_ack;
  logic                 clr_out;
  logic                 pc_redirect;
  logic [31:0]          pc_target;
  logic                 halt_out;
  logic [31:0]          commit_count;

  modport master (
    input  rdy_in, rob_head_valid, rob_head_done, rob_head_type, rob_head_rd,
           rob_head_val, rob_head_index, rob_head_mispred, rob_head_target, st_ack,
    output rob_pop, rf_ready, rf_reg_id, rf_reg_val, rf_rob_index, st_req,
           clr_out, pc_redirect, pc_target, halt_out, commit_count
  );

  modport slave (
    output rdy_in, rob_head_valid, rob_head_done, rob_head_type, rob_head_rd,
           rob_head_val, rob_head_index, rob_head_mispred, rob_head_target, st_ack,
    input  rob_pop, rf_ready, rf_reg_id, rf_reg_val, rf_rob_index, st_req,
           clr_out, pc_redirect, pc_target, halt_out, commit_count
  );
endinterface

// File: rtl/commit_controller.sv
`timescale 1ns/1ps
// commit_controller
//   In-order retirement sequencer between the ROB head and the RF commit port.
//   Pops at most one head per cycle; the RF write-back appears the cycle after
//   the pop. Handles store-retire handshakes, mispredict flushes and halt.
// Ports
//   clk_in : system clock
//   rst_in : asynchronous reset, active-high
//   bus    : commit_controller_if.master (head fields, pop, RF write-back,
//            store handshake, flush/redirect, halt, retire counter)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | normal retirement from the ROB head
// S_ST_WAIT | store at head, st_req high, waiting for LSB st_ack
// S_FLUSH   | mispredict drain, no retirement until counter reaches 0
// S_HALT    | halt retired, absorbing until reset
module commit_controller #(
  parameter int ROB_WIDTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  commit_controller_if.master bus
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] T_ALU    = 2'd0;
  localparam logic [1:0] T_BRANCH = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;
  localparam logic [1:0] T_HALT   = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_ST_WAIT, S_FLUSH, S_HALT} state_t;

  state_t               state_q;
  logic [CW-1:0]        flush_cnt_q;
  logic                 rf_ready_q;
  logic [4:0]           rf_reg_id_q;
  logic [31:0]          rf_reg_val_q;
  logic [ROB_WIDTH-1:0] rf_rob_index_q;
  logic                 st_req_q;
  logic                 clr_q;
  logic                 redirect_q;
  logic [31:0]          pc_target_q;
  logic                 halt_q;
  logic [31:0]          commit_count_q;

  logic head_ok;
  logic pop_d;

  assign head_ok = bus.rdy_in & bus.rob_head_valid & bus.rob_head_done;

  // Pop is gated by rst_in so that every output reads 0 while reset is held.
  always_comb begin
    pop_d = 1'b0;
    if (!rst_in && head_ok) begin
      case (state_q)
        S_RUN:     pop_d = (bus.rob_head_type != T_STORE);
        S_ST_WAIT: pop_d = bus.st_ack;
        default:   pop_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= S_RUN;
      flush_cnt_q    <= '0;
      rf_ready_q     <= 1'b0;
      rf_reg_id_q    <= '0;
      rf_reg_val_q   <= '0;
      rf_rob_index_q <= '0;
      st_req_q       <= 1'b0;
      clr_q          <= 1'b0;
      redirect_q     <= 1'b0;
      pc_target_q    <= '0;
      halt_q         <= 1'b0;
      commit_count_q <= '0;
    end else if (bus.rdy_in) begin
      rf_ready_q <= 1'b0;
      clr_q      <= 1'b0;
      redirect_q <= 1'b0;

      if (pop_d) begin
        commit_count_q <= commit_count_q + 32'd1;
        // Halt pops do not write the RF; everything else writes when rd != 0.
        if (bus.rob_head_type != T_HALT) begin
          rf_ready_q     <= (bus.rob_head_rd != 5'd0);
          rf_reg_id_q    <= bus.rob_head_rd;
          rf_reg_val_q   <= bus.rob_head_val;
          rf_rob_index_q <= bus.rob_head_index;
        end
      end

      case (state_q)
        S_RUN: begin
          if (bus.rob_head_valid && bus.rob_head_done) begin
            case (bus.rob_head_type)
              T_BRANCH: begin
                if (bus.rob_head_mispred) begin
                  clr_q       <= 1'b1;
                  redirect_q  <= 1'b1;
                  pc_target_q <= bus.rob_head_target;
                  flush_cnt_q <= CW'(FLUSH_CYCLES - 1);
                  state_q     <= S_FLUSH;
                end
              end
              T_STORE: begin
                st_req_q <= 1'b1;
                state_q  <= S_ST_WAIT;
              end
              T_HALT: begin
                halt_q  <= 1'b1;
                state_q <= S_HALT;
              end
              default: ;
            endcase
          end
        end
        S_ST_WAIT: begin
          if (pop_d) begin
            st_req_q <= 1'b0;
            state_q  <= S_RUN;
          end
        end
        S_FLUSH: begin
          // The clr cycle counts as the first no-retire cycle.
          if (flush_cnt_q == '0) state_q <= S_RUN;
          else                   flush_cnt_q <= flush_cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rob_pop      = pop_d;
  assign bus.rf_ready     = rf_ready_q;
  assign bus.rf_reg_id    = rf_reg_id_q;
  assign bus.rf_reg_val   = rf_reg_val_q;
  assign bus.rf_rob_index = rf_rob_index_q;
  assign bus.st_req       = st_req_q;
  assign bus.clr_out      = clr_q;
  assign bus.pc_redirect  = redirect_q;
  assign bus.pc_target    = pc_target_q;
  assign bus.halt_out     = halt_q;
  assign bus.commit_count = commit_count_q;

endmodule
